// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv issue/writeback controller.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  localparam int          CNT_W             = 8;
  localparam logic [4:0]  RSTATUS_REG_DEF   = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE_DEF = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE_DEF  = 32'd5;

  function automatic logic [31:0] exc_code(input logic is_div,
                                           input logic [31:0] mult_code,
                                           input logic [31:0] div_code);
    return is_div ? div_code : mult_code;
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Watchdog counter: clear wins over enable; tc flags count == TIMEOUT-1.
module md_cycle_counter
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/md_en_reg.sv
// Enable register primitive with async active-high clear.
module md_en_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller around multdiv: capture, one-cycle start pulse,
// stall until ready (or watchdog expiry), then a single writeback strobe.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter logic [4:0]  RSTATUS_REG   = RSTATUS_REG_DEF,
  parameter logic [31:0] MULT_EXC_CODE = MULT_EXC_CODE_DEF,
  parameter logic [31:0] DIV_EXC_CODE  = DIV_EXC_CODE_DEF,
  parameter int          TIMEOUT       = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_is_div,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  md_state_e   state_q, state_d;
  logic        cap_en, res_en, cnt_clr, cnt_en, cnt_tc;
  logic        is_div_q, exc_q, exc_d;
  logic [4:0]  rd_q;
  logic [31:0] result_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A watchdog expiry without ready is reported as an exception.
  assign exc_d = md_resultRDY ? md_exception : 1'b1;

  md_en_reg #(.W(32)) u_opa_reg (.clock, .reset, .en(cap_en), .d(in_opA),    .q(md_opA));
  md_en_reg #(.W(32)) u_opb_reg (.clock, .reset, .en(cap_en), .d(in_opB),    .q(md_opB));
  md_en_reg #(.W(5))  u_rd_reg  (.clock, .reset, .en(cap_en), .d(in_rd),     .q(rd_q));
  md_en_reg #(.W(1))  u_div_reg (.clock, .reset, .en(cap_en), .d(in_is_div), .q(is_div_q));
  md_en_reg #(.W(32)) u_res_reg (.clock, .reset, .en(res_en), .d(md_result), .q(result_q));
  md_en_reg #(.W(1))  u_exc_reg (.clock, .reset, .en(res_en), .d(exc_d),     .q(exc_q));

  md_cycle_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    cap_en       = 1'b0;
    res_en       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    stall        = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    unique case (state_q)
      ST_IDLE: begin
        stall = in_valid & ~reset;
        if (in_valid) begin
          cap_en  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        stall        = 1'b1;
        md_ctrl_MULT = ~is_div_q;
        md_ctrl_DIV  = is_div_q;
        cnt_clr      = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (md_resultRDY || cnt_tc) begin
          res_en  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // in_valid still shows the completing instruction here, so no capture.
        wb_valid = 1'b1;
        wb_rd    = exc_q ? RSTATUS_REG : rd_q;
        wb_data  = exc_q ? exc_code(is_div_q, MULT_EXC_CODE, DIV_EXC_CODE) : result_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: default-timeout DUT plus a TIMEOUT=8 copy.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_is_div = 1'b0;
  logic [31:0] in_opA = '0, in_opB = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0, md_resultRDY = 1'b0;

  logic        stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, busy;
  logic [31:0] md_opA, md_opB, wb_data;
  logic [4:0]  wb_rd;

  logic        t_stall, t_mult, t_div, t_wb_valid, t_busy;
  logic [31:0] t_opA, t_opB, t_wb_data;
  logic [4:0]  t_wb_rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_is_div(in_is_div),
    .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .stall(stall),
    .md_opA(md_opA), .md_opB(md_opB), .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .busy(busy)
  );

  multdiv_ctrl #(.TIMEOUT(8)) dut_t (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_is_div(in_is_div),
    .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .stall(t_stall),
    .md_opA(t_opA), .md_opB(t_opB), .md_ctrl_MULT(t_mult),
    .md_ctrl_DIV(t_div), .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY), .wb_valid(t_wb_valid), .wb_rd(t_wb_rd),
    .wb_data(t_wb_data), .busy(t_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one op at the current (IDLE) cycle, ready sampled at cycle 1+n.
  // Returns in the first IDLE cycle after DONE.
  task automatic run_op(input string name, input logic div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int n,
                        input logic [31:0] res, input logic exc, input logic hold,
                        input logic [4:0] exp_rd, input logic [31:0] exp_data);
    int mp, dp, st, wbs;
    mp = 0; dp = 0; st = 0; wbs = 0;
    for (int c = 0; c <= 2 + n; c++) begin
      if (c > 0) tick();
      if (c == 0) begin
        in_valid = 1'b1; in_is_div = div; in_opA = a; in_opB = b; in_rd = rd;
      end
      if (c == 1 && !hold) in_valid = 1'b0;
      if (c == 1 + n) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end
      if (c == 2 + n) begin
        md_resultRDY = 1'b0; md_exception = 1'b0;
      end
      #1;
      mp += int'(md_ctrl_MULT); dp += int'(md_ctrl_DIV);
      st += int'(stall); wbs += int'(wb_valid);
      if (c == 0) begin
        chk({name, ":stall_c0"}, stall, 1);
        chk({name, ":busy_c0"}, busy, 0);
      end
      if (c == 1) begin
        chk({name, ":mult_pulse_c1"}, md_ctrl_MULT, !div);
        chk({name, ":div_pulse_c1"}, md_ctrl_DIV, div);
        chk({name, ":opA"}, md_opA, a);
        chk({name, ":opB"}, md_opB, b);
      end
      if (c == 2 + n) begin
        chk({name, ":wb_valid"}, wb_valid, 1);
        chk({name, ":wb_rd"}, wb_rd, exp_rd);
        chk({name, ":wb_data"}, wb_data, exp_data);
        chk({name, ":stall_done"}, stall, 0);
        chk({name, ":opA_held"}, md_opA, a);
      end
    end
    tick();
    if (!hold) in_valid = 1'b0;
    chk({name, ":busy_after"}, busy, 0);
    chk({name, ":wb_after"}, wb_valid, 0);
    chk({name, ":mult_pulses"}, 32'(mp), div ? 0 : 1);
    chk({name, ":div_pulses"}, 32'(dp), div ? 1 : 0);
    chk({name, ":stall_cycles"}, 32'(st), 32'(2 + n));
    chk({name, ":wb_count"}, 32'(wbs), 1);
  endtask

  initial begin
    int tp, twb, lwb;
    #1;
    chk("rst:stall", stall, 0);
    chk("rst:busy", busy, 0);
    chk("rst:wb_valid", wb_valid, 0);
    chk("rst:ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    chk("rst:opA", md_opA, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 5'd5, 32, 32'd42, 1'b0, 1'b0, 5'd5, 32'd42);
    run_op("div100by0", 1'b1, 32'd100, 32'd0, 5'd9, 5, 32'd0, 1'b1, 1'b0, 5'd30, 32'd5);
    run_op("mul_ovf", 1'b0, 32'h7FFF_FFFF, 32'd2, 5'd4, 3, 32'hFFFF_FFFE, 1'b1, 1'b0,
           5'd30, 32'd4);
    run_op("mul_rd0", 1'b0, 32'd9, 32'd9, 5'd0, 1, 32'd81, 1'b0, 1'b0, 5'd0, 32'd81);
    run_op("hold_mul", 1'b0, 32'd3, 32'd4, 5'd7, 2, 32'd12, 1'b0, 1'b1, 5'd7, 32'd12);
    run_op("next_div", 1'b1, 32'd20, 32'd4, 5'd8, 1, 32'd5, 1'b0, 1'b0, 5'd8, 32'd5);

    // Ready/exception while idle must be ignored.
    md_resultRDY = 1'b1; md_exception = 1'b1;
    tick();
    chk("idle_rdy:wb_valid", wb_valid, 0);
    chk("idle_rdy:busy", busy, 0);
    md_resultRDY = 1'b0; md_exception = 1'b0;

    // Timeout on the TIMEOUT=8 copy; the default copy is reset mid-WAIT at cycle 12.
    tick();
    in_valid = 1'b1; in_is_div = 1'b0; in_opA = 32'd1; in_opB = 32'd1; in_rd = 5'd3;
    tp = 0; twb = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      if (c == 1) in_valid = 1'b0;
      #1;
      tp += int'(t_mult) + int'(t_div);
      twb += int'(t_wb_valid);
      if (c == 9) chk("tmo:stall_c9", t_stall, 1);
      if (c == 10) begin
        chk("tmo:wb_valid_c10", t_wb_valid, 1);
        chk("tmo:wb_rd", t_wb_rd, 30);
        chk("tmo:wb_data", t_wb_data, 4);
      end
      if (c == 11) chk("tmo:busy_c11", t_busy, 0);
    end
    chk("tmo:pulses", 32'(tp), 1);
    chk("tmo:wb_count", 32'(twb), 1);

    chk("rstwait:busy_before", busy, 1);
    chk("rstwait:stall_before", stall, 1);
    reset = 1'b1;
    #1;
    chk("rstwait:stall", stall, 0);
    chk("rstwait:busy", busy, 0);
    chk("rstwait:wb_valid", wb_valid, 0);
    chk("rstwait:opA", md_opA, 0);
    tick();
    reset = 1'b0;
    md_resultRDY = 1'b1; md_result = 32'hDEAD; md_exception = 1'b0;
    lwb = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      lwb += int'(wb_valid);
    end
    md_resultRDY = 1'b0;
    chk("rstwait:late_rdy_wb", 32'(lwb), 0);
    chk("rstwait:busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
